// File: rtl/vector_rf_sram_master_pkg.sv
// vrf_pkg: shared definitions for the vector register file SRAM master
// and the register file macro wrapper.
// Optional feature macro: VRF_MASTER_TURNAROUND_EN adds the TA state, which
// holds chip-select low for one cycle between a read burst and the next access.
package vrf_pkg;

  localparam int VRF_DATA_WIDTH = 64;
  localparam int VRF_ADDR_WIDTH = 7;

  // The state names what the SRAM pins show during the current cycle.
`ifdef VRF_MASTER_TURNAROUND_EN
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    DRAIN = 3'd3,
    TA    = 3'd4
  } vrf_state_e;
`else
  typedef enum logic [2:0] {
    IDLE  = 3'd0,
    WR    = 3'd1,
    RD    = 3'd2,
    DRAIN = 3'd3
  } vrf_state_e;
`endif

  typedef struct packed {
    logic                      we;
    logic [VRF_ADDR_WIDTH-1:0] addr;
    logic [VRF_DATA_WIDTH-1:0] wdata;
  } vrf_req_t;

  typedef struct packed {
    logic [VRF_DATA_WIDTH-1:0] data;
  } vrf_rsp_t;

  // SRAM control pins {cs, we, oe} that a state presents.
  function automatic logic [2:0] state_pins(input vrf_state_e s);
    logic [2:0] pins;
    case (s)
      WR:      pins = 3'b110;
      RD:      pins = 3'b101;
      DRAIN:   pins = 3'b101;
      default: pins = 3'b000;
    endcase
    return pins;
  endfunction

endpackage

// File: rtl/vector_rf_sram_master_if.sv
// Request/response channel between the vector execution pipeline (master)
// and the SRAM controller (slave).
interface vector_rf_sram_master_if #(
  parameter int DATA_WIDTH = vrf_pkg::VRF_DATA_WIDTH,
  parameter int ADDR_WIDTH = vrf_pkg::VRF_ADDR_WIDTH
) ();

  logic                  req_valid;
  logic                  req_ready;
  logic                  req_we;
  logic [ADDR_WIDTH-1:0] req_addr;
  logic [DATA_WIDTH-1:0] req_wdata;
  logic                  rsp_valid;
  logic [DATA_WIDTH-1:0] rsp_data;

  modport master (
    output req_valid, req_we, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_data
  );

  modport slave (
    input  req_valid, req_we, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_data
  );

endinterface

// File: rtl/vector_rf_sram_master.sv
// vector_rf_sram_master: turns a single-word read/write request stream into
// sequenced cs/we/oe activity on the vector register file SRAM, pipelining
// reads at one per cycle and draining the shared bus before any write.
// Optional feature macro: VRF_MASTER_TURNAROUND_EN (extra TA cycle after DRAIN).
module vector_rf_sram_master
  import vrf_pkg::*;
#(
  parameter int DATA_WIDTH = VRF_DATA_WIDTH,
  parameter int ADDR_WIDTH = VRF_ADDR_WIDTH
) (
  input  logic                  clk,
  input  logic                  rst_n,
  vector_rf_sram_master_if.slave req_if,
  output logic [ADDR_WIDTH-1:0] sram_address,
  output logic                  sram_cs,
  output logic                  sram_we,
  output logic                  sram_oe,
  inout  wire  [DATA_WIDTH-1:0] sram_data,
  output logic                  busy
);

  vrf_state_e            state_r;
  vrf_state_e            state_next_s;
  logic                  ready_s;
  logic                  accept_s;
  logic [2:0]            pins_next_s;
  logic                  cs_r;
  logic                  we_r;
  logic                  oe_r;
  logic [ADDR_WIDTH-1:0] addr_r;
  logic [DATA_WIDTH-1:0] wdata_r;
  logic                  rd_pend_r;
  logic                  rsp_valid_r;
  logic [DATA_WIDTH-1:0] rsp_data_r;
  logic                  busy_r;

  assign accept_s    = req_if.req_valid && ready_s;
  assign pins_next_s = state_pins(state_next_s);

  // Next-state and request-ready decode; writes are held off while read data may still own the bus.
  always_comb begin
    state_next_s = state_r;
    ready_s      = 1'b0;
    case (state_r)
      IDLE, WR: begin
        ready_s = 1'b1;
        if (req_if.req_valid) begin
          state_next_s = req_if.req_we ? WR : RD;
        end else begin
          state_next_s = IDLE;
        end
      end
      RD: begin
        ready_s = !req_if.req_we;
        if (req_if.req_valid && !req_if.req_we) begin
          state_next_s = RD;
        end else begin
          state_next_s = DRAIN;
        end
      end
`ifdef VRF_MASTER_TURNAROUND_EN
      DRAIN: begin
        ready_s = !req_if.req_we;
        if (req_if.req_valid && !req_if.req_we) begin
          state_next_s = RD;
        end else begin
          state_next_s = TA;
        end
      end
      TA: begin
        ready_s = 1'b1;
        if (req_if.req_valid) begin
          state_next_s = req_if.req_we ? WR : RD;
        end else begin
          state_next_s = IDLE;
        end
      end
`else
      DRAIN: begin
        ready_s = 1'b1;
        if (req_if.req_valid) begin
          state_next_s = req_if.req_we ? WR : RD;
        end else begin
          state_next_s = IDLE;
        end
      end
`endif
      default: begin
        ready_s      = 1'b0;
        state_next_s = IDLE;
      end
    endcase
  end

  // State register.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_r <= IDLE;
    end else begin
      state_r <= state_next_s;
    end
  end

  // SRAM pin registers: controls follow the next state so they appear in the cycle after acceptance.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cs_r    <= 1'b0;
      we_r    <= 1'b0;
      oe_r    <= 1'b0;
      addr_r  <= {ADDR_WIDTH{1'b0}};
      wdata_r <= {DATA_WIDTH{1'b0}};
    end else begin
      cs_r <= pins_next_s[2];
      we_r <= pins_next_s[1];
      oe_r <= pins_next_s[0];
      if (accept_s) begin
        addr_r <= req_if.req_addr;
      end
      if (accept_s && req_if.req_we) begin
        wdata_r <= req_if.req_wdata;
      end
    end
  end

  // Read capture: the cycle after every RD cycle the bus holds that read's data.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_pend_r   <= 1'b0;
      rsp_valid_r <= 1'b0;
      rsp_data_r  <= {DATA_WIDTH{1'b0}};
    end else begin
      rd_pend_r   <= (state_r == RD);
      rsp_valid_r <= rd_pend_r;
      if (rd_pend_r) begin
        rsp_data_r <= sram_data;
      end
    end
  end

  // Busy flag, registered to match state_r/rd_pend_r of the following cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      busy_r <= 1'b0;
    end else begin
      busy_r <= (state_next_s != IDLE) || (state_r == RD);
    end
  end

  assign sram_cs      = cs_r;
  assign sram_we      = we_r;
  assign sram_oe      = oe_r;
  assign sram_address = addr_r;
  assign busy         = busy_r;

  assign req_if.req_ready = ready_s;
  assign req_if.rsp_valid = rsp_valid_r;
  assign req_if.rsp_data  = rsp_data_r;

  // The master only drives the bus during a write cycle.
  assign sram_data = (cs_r && we_r) ? wdata_r : {DATA_WIDTH{1'bz}};

endmodule
